instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the RISC-V core, directly upstream of `main_decode`. It holds the program counter and runs a request/acknowledge handshake with instruction memory. It presents the fetched instruction and its `op` field to the decoder, then advances the PC when the core signals retirement. It also computes `PCSrc` internally, as `branch & zero`, from the decoder's `branch` output and the ALU's `zero` flag.

## Interface
- `XLEN`, 32, PC and address width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  XLEN  fetch address; equals `pc`.
- `imem_ack`  in  1  instruction memory has returned data this cycle.
- `imem_rdata`  in  32  instruction word; valid when `imem_ack` is high.
- `branch`  in  1  from `main_decode`.
- `zero`  in  1  from the ALU.
- `imm_ext`  in  XLEN  sign-extended immediate (B-type offset for branches).
- `retire`  in  1  one-cycle pulse: the current instruction has completed execution.
- `instr_valid`  out  1  `instr` and `op` hold a valid fetched instruction.
- `instr`  out  32  registered instruction word.
- `op`  out  7  `instr[6:0]`, fed to `main_decode`.
- `pc`  out  XLEN  address of `instr`.
- `pc_plus4`  out  XLEN  `pc + 4`.
- `misalign`  out  1  sticky misaligned-target flag; present only with `FETCH_MISALIGN_TRAP_EN`.

## Operation
- FSM states: IDLE, FETCH, HOLD, plus HALT when `FETCH_MISALIGN_TRAP_EN` is defined.
- Reset values:
  - state IDLE; `pc = RESET_PC`; `instr = 32'h0000_0013` (NOP), so `op = 7'b0010011`.
  - `instr_valid = 0`, `imem_req = 0`, `misalign = 0`.
- IDLE: move to FETCH unconditionally on the next edge.
- FETCH:
  - `imem_req = 1`; `imem_addr = pc`, held stable until ack.
  - On `imem_ack`: latch `imem_rdata` into `instr`, set `instr_valid`, go to HOLD.
- HOLD:
  - `imem_req = 0`, `instr_valid = 1`.
  - On `retire`: compute `target`, load `pc <= target`, clear `instr_valid`, go to FETCH.
  - `target = (branch & zero) ? pc + imm_ext : pc + 4`.
- `imem_ack` outside FETCH is ignored. `retire` outside HOLD is ignored.
- Arithmetic: all PC sums are XLEN bits, modulo 2^XLEN, so 32'hFFFF_FFFC + 4 = 32'h0000_0000. No carry is kept.
- `branch`, `zero` and `imm_ext` are sampled only in the retire cycle.
- Reset mid-operation: any state returns to the reset values immediately. A pending request is dropped, and an ack in a later cycle is ignored until the next FETCH.

## Timing
- Reset release to the first `imem_req`: 1 cycle (IDLE, then FETCH).
- `imem_ack` may arrive in the first cycle of FETCH or any later cycle.
- `instr_valid` rises on the edge that samples `imem_ack`, and is visible the cycle after the ack.
- `retire` to the next `imem_req`: `imem_req` is high in the cycle after the retire edge, with `imem_addr` already set to the new PC.
- Minimum throughput: one instruction per 2 cycles, with ack in the first FETCH cycle and `retire` in the first HOLD cycle.
- All outputs are registered or decoded from state. `pc_plus4` is combinational from `pc`.

## Configuration
- Macro: `FETCH_MISALIGN_TRAP_EN`.
- Defined:
  - If `target[1:0] != 2'b00` at retire, set `misalign`, leave `pc` unchanged, enter HALT.
  - HALT keeps `imem_req = 0` and `instr_valid = 0` until reset.
- Not defined:
  - The `misalign` port and the HALT state do not exist.
  - The PC loads `{target[XLEN-1:2], 2'b00}`.

## Structure
- Shared package `riscv_pkg`:
  - FSM state enum.
  - `NOP_INSTR` constant.
  - Opcode constants already used by the decoder: `OP_LOAD` 0000011, `OP_STORE` 0100011, `OP_RTYPE` 0110011, `OP_BRANCH` 1100011.
- One combinational sub-module, `pc_next`: inputs `pc`, `imm_ext`, `branch`, `zero`; outputs `target` and `pcsrc`.

## Test plan
- Reset and first fetch:
  - Stimulus: assert `rst`, release; ack in the 1st FETCH cycle with 32'h0000_0033.
  - Required: one cycle after release, `imem_req = 1` with `imem_addr = 0`. After the ack, `instr_valid = 1`, `op = 7'b0110011`, `pc = 0`.
- Sequential advance:
  - Stimulus: retire with `branch = 0`.
  - Required: next `imem_addr = 32'h4`; `pc_plus4 = 32'h8` once the PC updates.
- Taken branch:
  - Stimulus: `pc = 32'h10`, `branch = 1`, `zero = 1`, `imm_ext = 32'hFFFF_FFF8`, retire.
  - Required: next `imem_addr = 32'h8`.
  - Repeat with `zero = 0`: next `imem_addr = 32'h14`.
- Wait states and stray inputs:
  - Stimulus: hold ack low for 3 FETCH cycles; pulse `retire` during FETCH; pulse `imem_ack` during HOLD.
  - Required: `imem_addr` stays stable; `instr` and `pc` are unchanged by the stray pulses.
- Wrap and mid-fetch reset:
  - Stimulus: `pc = 32'hFFFF_FFFC`, retire, then assert `rst` while `imem_req = 1`.
  - Required: next fetch at 32'h0. After the reset, `pc = RESET_PC`, `instr = 32'h0000_0013`, `imem_req = 0`.
- Misaligned target:
  - Stimulus: `imm_ext = 32'h2`, branch taken.
  - Required with `FETCH_MISALIGN_TRAP_EN`: `misalign = 1`, `imem_req` stays low.
  - Required without it: next `imem_addr = pc` (offset 2, masked).

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: fetch FSM states, NOP encoding and base opcodes.
// The HALT state exists only when FETCH_MISALIGN_TRAP_EN is defined.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
      , HALT
`endif
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next-PC selection: branch target when the decoder's branch meets the ALU zero
// flag, otherwise the sequential address. All sums wrap modulo 2^XLEN.
module pc_next #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm_ext,
   input  logic            branch,
   input  logic            zero,
   output logic [XLEN-1:0] target,
   output logic            pcsrc
);

   assign pcsrc  = branch & zero;
   assign target = pcsrc ? (pc + imm_ext) : (pc + XLEN'(4));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register plus req/ack handshake with instruction memory.
// Optional FETCH_MISALIGN_TRAP_EN halts fetch on a misaligned target instead of masking it.
module instr_fetch
   import riscv_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   input  logic            branch,
   input  logic            zero,
   input  logic [XLEN-1:0] imm_ext,
   input  logic            retire,
   output logic            instr_valid,
   output logic [31:0]     instr,
   output logic [6:0]      op,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic            misalign
`endif
);

   fetch_state_t    state;
   logic [XLEN-1:0] target;
   logic            pcsrc;

   pc_next #(.XLEN(XLEN)) u_pc_next (
      .pc      (pc),
      .imm_ext (imm_ext),
      .branch  (branch),
      .zero    (zero),
      .target  (target),
      .pcsrc   (pcsrc)
   );

   assign imem_addr = pc;
   assign op        = instr[6:0];
   assign pc_plus4  = pc + XLEN'(4);

   // NOTE: every register here is state, so only non-blocking assignments are used;
   // the reset branch is asynchronous and must be the first test in the block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         instr       <= NOP_INSTR;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               imem_req <= 1'b1;
               state    <= FETCH;
            end

            FETCH: begin
               if (imem_ack) begin
                  instr       <= imem_rdata;
                  instr_valid <= 1'b1;
                  imem_req    <= 1'b0;
                  state       <= HOLD;
               end
            end

            HOLD: begin
               if (retire) begin
                  instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                  // Only a taken branch can produce a misaligned target.
                  if (pcsrc && (target[1:0] != 2'b00)) begin
                     misalign <= 1'b1;
                     state    <= HALT;
                  end else begin
                     pc       <= target;
                     imem_req <= 1'b1;
                     state    <= FETCH;
                  end
`else
                  // Sequential targets are aligned by construction; mask branch offsets.
                  pc       <= pcsrc ? {target[XLEN-1:2], 2'b00} : target;
                  imem_req <= 1'b1;
                  state    <= FETCH;
`endif
               end
            end

`ifdef FETCH_MISALIGN_TRAP_EN
            HALT: begin
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end
`endif

            default: begin
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Table-driven bench for instr_fetch: per-cycle vectors plus reset and misalign sequences.
// Expectations for the misaligned branch follow FETCH_MISALIGN_TRAP_EN.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        branch;
   logic        zero;
   logic [31:0] imm_ext;
   logic        retire;
   logic        instr_valid;
   logic [31:0] instr;
   logic [6:0]  op;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .branch      (branch),
      .zero        (zero),
      .imm_ext     (imm_ext),
      .retire      (retire),
      .instr_valid (instr_valid),
      .instr       (instr),
      .op          (op),
      .pc          (pc),
      .pc_plus4    (pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .misalign    (misalign)
`endif
   );

   typedef struct {
      logic        ack;
      logic [31:0] rdata;
      logic        ret;
      logic        br;
      logic        zr;
      logic [31:0] imm;
      logic        exp_req;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Called at a negedge: drive inputs, let one rising edge pass, compare #1 later.
   task automatic apply(input string tag, input vec_t v);
      logic [6:0]  exp_op;
      logic [31:0] exp_p4;
      imem_ack   = v.ack;
      imem_rdata = v.rdata;
      retire     = v.ret;
      branch     = v.br;
      zero       = v.zr;
      imm_ext    = v.imm;
      @(posedge clk);
      #1;
      exp_op = v.exp_instr[6:0];
      exp_p4 = v.exp_pc + 32'd4;
      check({tag, " imem_req"},    {31'd0, imem_req},    {31'd0, v.exp_req});
      check({tag, " instr_valid"}, {31'd0, instr_valid}, {31'd0, v.exp_valid});
      check({tag, " imem_addr"},   imem_addr,            v.exp_pc);
      check({tag, " pc"},          pc,                   v.exp_pc);
      check({tag, " pc_plus4"},    pc_plus4,             exp_p4);
      check({tag, " instr"},       instr,                v.exp_instr);
      check({tag, " op"},          {25'd0, op},          {25'd0, exp_op});
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      // ack, rdata, retire, branch, zero, imm, exp_req, exp_valid, exp_pc, exp_instr
      vecs.push_back('{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h0000_0013});
      vecs.push_back('{1'b1, 32'h0000_0033, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h0000_0033});
      vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h4,         32'h0000_0033});
      vecs.push_back('{1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h4,         32'h0000_0013});
      vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h40,        1'b1, 1'b0, 32'h8,         32'h0000_0013});
      vecs.push_back('{1'b1, 32'h0010_0093, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'h0010_0093});
      vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h40,        1'b1, 1'b0, 32'hC,         32'h0010_0093});
      vecs.push_back('{1'b1, 32'h0000_0033, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hC,         32'h0000_0033});
      vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h10,        32'h0000_0033});
      vecs.push_back('{1'b1, 32'h0020_8463, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h10,        32'h0020_8463});
      // taken branch backwards from 0x10
      vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h8,         32'h0020_8463});
      vecs.push_back('{1'b1, 32'h0020_8463, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'h0020_8463});
      vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h8,         1'b1, 1'b0, 32'h10,        32'h0020_8463});
      vecs.push_back('{1'b1, 32'h0020_8463, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h10,        32'h0020_8463});
      // same branch, zero low: falls through
      vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h14,        32'h0020_8463});
      // wait states, then stray retire during FETCH
      vecs.push_back('{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h14,        32'h0020_8463});
      vecs.push_back('{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h14,        32'h0020_8463});
      vecs.push_back('{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h14,        32'h0020_8463});
      vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h100,       1'b1, 1'b0, 32'h14,        32'h0020_8463});
      vecs.push_back('{1'b1, 32'h00A0_0093, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h14,        32'h00A0_0093});
      // stray ack during HOLD, then idle HOLD cycle
      vecs.push_back('{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h14,        32'h00A0_0093});
      vecs.push_back('{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h14,        32'h00A0_0093});
      // jump to the top of the address space, then wrap
      vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'hFFFF_FFE8, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h00A0_0093});
      vecs.push_back('{1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0013});
      vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h0000_0013});

      rst        = 1'b1;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      retire     = 1'b0;
      branch     = 1'b0;
      zero       = 1'b0;
      imm_ext    = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("reset imem_req",    {31'd0, imem_req},    32'd0);
      check("reset instr_valid", {31'd0, instr_valid}, 32'd0);
      check("reset pc",          pc,                   32'h0);
      check("reset instr",       instr,                32'h0000_0013);
      check("reset op",          {25'd0, op},          32'h13);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("reset misalign",    {31'd0, misalign},    32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++)
         apply($sformatf("vec%0d", i), vecs[i]);

      // Asynchronous reset while a request to 0x0 is outstanding
      imem_ack = 1'b0;
      retire   = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("midrst imem_req",    {31'd0, imem_req},    32'd0);
      check("midrst instr_valid", {31'd0, instr_valid}, 32'd0);
      check("midrst pc",          pc,                   32'h0);
      check("midrst instr",       instr,                32'h0000_0013);
      @(negedge clk);
      rst = 1'b0;

      // Ack arriving in IDLE is ignored
      v = '{1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0000_0013};
      apply("idle_ack", v);
      v = '{1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0000_0003};
      apply("refetch", v);

      // Taken branch with offset 2
`ifdef FETCH_MISALIGN_TRAP_EN
      v = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h2, 1'b0, 1'b0, 32'h0, 32'h0000_0003};
      apply("misalign_retire", v);
      check("misalign flag", {31'd0, misalign}, 32'd1);
      v = '{1'b1, 32'h0000_0033, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_0003};
      apply("halt_hold", v);
      check("halt misalign", {31'd0, misalign}, 32'd1);
`else
      v = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h2, 1'b1, 1'b0, 32'h0, 32'h0000_0003};
      apply("mask_retire", v);
      v = '{1'b1, 32'h0000_0033, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0000_0033};
      apply("mask_fetch", v);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
